// File: rtl/bist_tpg_ctrl.sv
// bist_tpg_ctrl: pattern-generation controller for a BIST session.
// An internal-XOR LFSR emits one pseudo-random pattern per RUN cycle, both in
// parallel (pat_out) and serially (sout = pat_out[0]). sa_en enables the
// downstream signature analyser on exactly the cycles patterns are valid.
// After the last pattern the block waits one cycle for the analyser to
// settle, compares sig_in against golden and pulses done with the result on
// pass (held until the next accepted start).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               session request, sampled only in IDLE
//   poly                feedback taps (bit i = XOR tap into stage i)
//   seed                LFSR start value (all-zero is replaced by 1)
//   num_patterns        session length, 0 means 2^CW patterns
//   golden, sig_in      expected / returned signature
//   pat_out, sout       current pattern, serial bit
//   pat_valid, sa_en    pattern valid / analyser enable (identical)
//   busy, done, pass    status: in session, end-of-session pulse, result
//   abort, aborted      only with TPG_ABORT_EN: cancel a session / sticky flag
//
// Optional build macro: TPG_ABORT_EN adds the abort/aborted ports.
module bist_tpg_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  poly,
  input  logic [N-1:0]  seed,
  input  logic [CW-1:0] num_patterns,
  input  logic [N-1:0]  golden,
  input  logic [N-1:0]  sig_in,
`ifdef TPG_ABORT_EN
  input  logic          abort,
  output logic          aborted,
`endif
  output logic [N-1:0]  pat_out,
  output logic          sout,
  output logic          pat_valid,
  output logic          sa_en,
  output logic          busy,
  output logic          done,
  output logic          pass
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_SIG, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  lfsr, lfsr_adv;
  logic [CW-1:0] count;
  logic          last_pat;
  logic          abort_req;

`ifdef TPG_ABORT_EN
  assign abort_req = abort && ((state == RUN) || (state == WAIT_SIG));
`else
  assign abort_req = 1'b0;
`endif

  // Internal-XOR shift toward stage 0; stage 0 feeds back into every tapped stage.
  always_comb begin
    lfsr_adv = '0;
    lfsr_adv[N-1] = lfsr[0];
    for (int unsigned i = 0; i < N - 1; i++) begin
      lfsr_adv[i] = (lfsr[0] & poly[i]) ^ lfsr[i+1];
    end
  end

  // Modulo-2^CW compare: num_patterns == 0 wraps to all-ones, giving 2^CW patterns.
  assign last_pat = (count == (num_patterns - CW'(1)));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    pat_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        pat_valid = 1'b1;
        if (last_pat) state_nxt = WAIT_SIG;
      end
      WAIT_SIG: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_req) state_nxt = IDLE;
  end

  assign sa_en   = pat_valid;
  assign pat_out = lfsr;
  assign sout    = lfsr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= '0;
      count <= '0;
      pass  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            lfsr  <= (seed == '0) ? N'(1) : seed;
            count <= '0;
            pass  <= 1'b0;
          end
        end
        RUN: begin
          lfsr  <= lfsr_adv;
          count <= count + CW'(1);
        end
        WAIT_SIG: pass <= (sig_in == golden);
        default: ;
      endcase
      if (abort_req) pass <= 1'b0;
    end
  end

`ifdef TPG_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        aborted <= 1'b0;
    else if (abort_req)             aborted <= 1'b1;
    else if (state == IDLE && start) aborted <= 1'b0;
  end
`endif

endmodule
